// File: rtl/taxi_meter_core_if.sv
// Signal bundle between the key/encoder front end and the fare-metering core.
// The bench drives the master side; the core sits on the slave side.
interface taxi_meter_core_if #(
   parameter int DIST_W  = 20,
   parameter int PRICE_W = 20
);
   logic               encoder_pulses;
   logic               flag_launch;
   logic               flag_stop;
   logic               night_mode;
   logic [DIST_W-1:0]  distance;
   logic [PRICE_W-1:0] price;
   logic [1:0]         state;
   logic               waiting;
   logic               fare_valid;
   logic               overflow;

   modport master (
      output encoder_pulses, flag_launch, flag_stop, night_mode,
      input  distance, price, state, waiting, fare_valid, overflow
   );

   modport slave (
      input  encoder_pulses, flag_launch, flag_stop, night_mode,
      output distance, price, state, waiting, fare_valid, overflow
   );
endinterface

// File: rtl/taxi_meter_core.sv
// Taxi fare engine: synchronises the encoder, runs the IDLE/RUN/WAIT/HOLD trip FSM
// and accumulates distance and saturating fare (base, day/night rate, waiting charge).
module taxi_meter_core #(
   parameter int PULSES_PER_UNIT   = 10,
   parameter int BASE_FARE         = 80,
   parameter int BASE_DIST         = 3,
   parameter int RATE_DAY          = 15,
   parameter int RATE_NIGHT        = 20,
   parameter int WAIT_TICKS        = 100_000_000,
   parameter int WAIT_CHARGE_TICKS = 50_000_000,
   parameter int WAIT_RATE         = 5,
   parameter int DIST_W            = 20,
   parameter int PRICE_W           = 20
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   taxi_meter_core_if.slave       bus
);

   localparam int PCNT_W = $clog2(PULSES_PER_UNIT);
   localparam int IDLE_W = $clog2(WAIT_TICKS + 1);
   localparam int WCNT_W = $clog2(WAIT_CHARGE_TICKS + 1);

   localparam logic [PCNT_W-1:0]  PCNT_LAST    = PCNT_W'(PULSES_PER_UNIT - 1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST    = IDLE_W'(WAIT_TICKS - 1);
   localparam logic [WCNT_W-1:0]  WCNT_LAST    = WCNT_W'(WAIT_CHARGE_TICKS - 1);
   localparam logic [DIST_W-1:0]  BASE_DIST_V  = DIST_W'(BASE_DIST);
   localparam logic [PRICE_W-1:0] BASE_FARE_V  = PRICE_W'(BASE_FARE);
   localparam logic [PRICE_W-1:0] RATE_DAY_V   = PRICE_W'(RATE_DAY);
   localparam logic [PRICE_W-1:0] RATE_NIGHT_V = PRICE_W'(RATE_NIGHT);
   localparam logic [PRICE_W-1:0] WAIT_RATE_V  = PRICE_W'(WAIT_RATE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [DIST_W-1:0]  dist_reg, dist_next;
   logic [PRICE_W-1:0] price_reg, price_next;
   logic [PCNT_W-1:0]  pcnt_reg, pcnt_next;
   logic [IDLE_W-1:0]  idle_reg, idle_next;
   logic [WCNT_W-1:0]  wcnt_reg, wcnt_next;
   logic               night_reg, night_next;
   logic               ovf_reg, ovf_next;
   logic               fv_reg, fv_next;
   logic               waiting_reg, waiting_next;

   logic [1:0]         sync_reg;
   logic               prev_reg;
   logic               enc_edge;
   logic               start_trip;
   logic [DIST_W:0]    dist_sum;
   logic [PRICE_W:0]   price_sum;

   // Saturating add; MSB of the result flags that the sum was clamped.
   function automatic logic [PRICE_W:0] add_price(input logic [PRICE_W-1:0] a,
                                                  input logic [PRICE_W-1:0] b);
      logic [PRICE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[PRICE_W])
         s = {1'b1, {PRICE_W{1'b1}}};
      return s;
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_reg <= 2'b00;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], bus.encoder_pulses};
         prev_reg <= sync_reg[1];
      end
   end

   assign enc_edge = sync_reg[1] & ~prev_reg;

   always_comb begin
      state_next = state_reg;
      dist_next  = dist_reg;
      price_next = price_reg;
      pcnt_next  = pcnt_reg;
      idle_next  = idle_reg;
      wcnt_next  = wcnt_reg;
      night_next = night_reg;
      ovf_next   = ovf_reg;
      fv_next    = 1'b0;
      dist_sum   = '0;
      price_sum  = '0;
      start_trip = bus.flag_launch && (state_reg == S_IDLE || state_reg == S_HOLD);

      if (start_trip) begin
         state_next = S_RUN;
         dist_next  = '0;
         price_next = BASE_FARE_V;
         pcnt_next  = '0;
         idle_next  = '0;
         wcnt_next  = '0;
         night_next = bus.night_mode;
         ovf_next   = 1'b0;
      end else begin
         case (state_reg)
            S_RUN, S_WAIT: begin
               if (bus.flag_stop) begin
                  state_next = S_HOLD;
                  fv_next    = 1'b1;
               end else if (enc_edge) begin
                  // An edge in WAIT resumes the trip and drops the partial wait count.
                  state_next = S_RUN;
                  idle_next  = '0;
                  wcnt_next  = '0;
                  if (pcnt_reg == PCNT_LAST) begin
                     pcnt_next = '0;
                     dist_sum  = {1'b0, dist_reg} + (DIST_W + 1)'(1);
                     if (dist_sum[DIST_W]) begin
                        dist_next = '1;
                        ovf_next  = 1'b1;
                     end else begin
                        dist_next = dist_sum[DIST_W-1:0];
                     end
                     if (dist_next > BASE_DIST_V) begin
                        price_sum  = add_price(price_reg, night_reg ? RATE_NIGHT_V : RATE_DAY_V);
                        price_next = price_sum[PRICE_W-1:0];
                        ovf_next   = ovf_next | price_sum[PRICE_W];
                     end
                  end else begin
                     pcnt_next = pcnt_reg + PCNT_W'(1);
                  end
               end else if (state_reg == S_RUN) begin
                  idle_next = idle_reg + IDLE_W'(1);
                  if (idle_reg == IDLE_LAST) begin
                     state_next = S_WAIT;
                     wcnt_next  = '0;
                  end
               end else begin
                  if (wcnt_reg == WCNT_LAST) begin
                     wcnt_next  = '0;
                     price_sum  = add_price(price_reg, WAIT_RATE_V);
                     price_next = price_sum[PRICE_W-1:0];
                     ovf_next   = ovf_reg | price_sum[PRICE_W];
                  end else begin
                     wcnt_next = wcnt_reg + WCNT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (bus.flag_stop) begin
                  state_next = S_IDLE;
                  dist_next  = '0;
                  price_next = '0;
                  pcnt_next  = '0;
                  idle_next  = '0;
                  wcnt_next  = '0;
               end
            end
            default: begin
            end
         endcase
      end

      waiting_next = (state_next == S_WAIT);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg   <= S_IDLE;
         dist_reg    <= '0;
         price_reg   <= '0;
         pcnt_reg    <= '0;
         idle_reg    <= '0;
         wcnt_reg    <= '0;
         night_reg   <= 1'b0;
         ovf_reg     <= 1'b0;
         fv_reg      <= 1'b0;
         waiting_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         dist_reg    <= dist_next;
         price_reg   <= price_next;
         pcnt_reg    <= pcnt_next;
         idle_reg    <= idle_next;
         wcnt_reg    <= wcnt_next;
         night_reg   <= night_next;
         ovf_reg     <= ovf_next;
         fv_reg      <= fv_next;
         waiting_reg <= waiting_next;
      end
   end

   assign bus.distance   = dist_reg;
   assign bus.price      = price_reg;
   assign bus.state      = state_reg;
   assign bus.waiting    = waiting_reg;
   assign bus.fare_valid = fv_reg;
   assign bus.overflow   = ovf_reg;

endmodule

// File: tb/tb_taxi_meter_core.sv
// Two cores (20-bit and 8-bit price) share one directed stimulus; each is checked every
// cycle against a trip-level fare model, plus hand-computed literal checkpoints.
module tb_taxi_meter_core;

   localparam int PPU = 4;
   localparam int BF  = 80;
   localparam int BD  = 3;
   localparam int RN  = 20;
   localparam int WT  = 100;
   localparam int WCT = 50;
   localparam int WR  = 5;
   localparam int DW  = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic pin, launch, stop, night;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_rise = 0;

   int dist_o[2], price_o[2], state_o[2], wait_o[2], fv_o[2], ovf_o[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      chk(name, act, exp);
      if (act == exp)
         $display("check %s: got %0d as expected (cycle %0d)", name, act, cyc);
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int PW = (gi == 0) ? 20 : 8;
      localparam int RD = (gi == 0) ? 15 : 100;
      localparam longint DMAX = (longint'(1) << DW) - 1;
      localparam longint PMAX = (longint'(1) << PW) - 1;

      taxi_meter_core_if #(.DIST_W(DW), .PRICE_W(PW)) bus ();

      assign bus.encoder_pulses = pin;
      assign bus.flag_launch    = launch;
      assign bus.flag_stop      = stop;
      assign bus.night_mode     = night;

      taxi_meter_core #(
         .PULSES_PER_UNIT(PPU), .BASE_FARE(BF), .BASE_DIST(BD),
         .RATE_DAY(RD), .RATE_NIGHT(RN), .WAIT_TICKS(WT),
         .WAIT_CHARGE_TICKS(WCT), .WAIT_RATE(WR), .DIST_W(DW), .PRICE_W(PW)
      ) u_dut (
         .sys_clk  (clk),
         .sys_rst_n(rst_n),
         .bus      (bus.slave)
      );

      assign dist_o[gi]  = int'(bus.distance);
      assign price_o[gi] = int'(bus.price);
      assign state_o[gi] = int'(bus.state);
      assign wait_o[gi]  = int'(bus.waiting);
      assign fv_o[gi]    = int'(bus.fare_valid);
      assign ovf_o[gi]   = int'(bus.overflow);

      // Trip model: counts accepted edges and waiting charges, derives the fare in one formula.
      bit     s0, s1, pv, e;
      int     mst, medges, midle, mwt, mch, mfv, movf, mnight;
      longint munits, mraw;
      int     edist, eprice;

      initial begin
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               s0 = 0; s1 = 0; pv = 0;
               mst = 0; medges = 0; midle = 0; mwt = 0; mch = 0;
               mfv = 0; movf = 0; mnight = 0; edist = 0; eprice = 0;
            end else begin
               e  = s1 & ~pv;
               pv = s1; s1 = s0; s0 = pin;
               mfv = 0;
               if (launch && (mst == 0 || mst == 3)) begin
                  mst = 1; medges = 0; midle = 0; mwt = 0; mch = 0;
                  movf = 0; mnight = night;
               end else if (mst == 3) begin
                  if (stop) begin
                     mst = 0; medges = 0; mch = 0;
                  end
               end else if (mst != 0) begin
                  if (stop) begin
                     mst = 3; mfv = 1;
                  end else if (e) begin
                     medges++; midle = 0; mwt = 0; mst = 1;
                  end else if (mst == 1) begin
                     midle++;
                     if (midle == WT) begin
                        mst = 2; mwt = 0;
                     end
                  end else begin
                     mwt++;
                     if (mwt == WCT) begin
                        mch++; mwt = 0;
                     end
                  end
               end
               munits = medges / PPU;
               mraw   = BF + ((munits > BD) ? (munits - BD) * (mnight ? RN : RD) : 0) + WR * mch;
               if (mst != 0 && (munits > DMAX || mraw > PMAX))
                  movf = 1;
               edist  = (mst == 0) ? 0 : int'((munits > DMAX) ? DMAX : munits);
               eprice = (mst == 0) ? 0 : int'((mraw > PMAX) ? PMAX : mraw);
            end
         end
      end

      initial begin
         forever begin
            @(negedge clk);
            chk($sformatf("d%0d_distance", gi), dist_o[gi], edist);
            chk($sformatf("d%0d_price", gi), price_o[gi], eprice);
            chk($sformatf("d%0d_state", gi), state_o[gi], mst);
            chk($sformatf("d%0d_waiting", gi), wait_o[gi], (mst == 2) ? 1 : 0);
            chk($sformatf("d%0d_fare_valid", gi), fv_o[gi], mfv);
            chk($sformatf("d%0d_overflow", gi), ovf_o[gi], movf);
         end
      end
   end

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); pin = 1'b1; last_rise = cyc;
         @(negedge clk);
         @(negedge clk); pin = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic tap_launch(input bit n);
      @(negedge clk); night = n; launch = 1'b1;
      @(negedge clk); launch = 1'b0;
   endtask

   task automatic tap_stop();
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic wait_for_wait(output int n);
      n = 0;
      while (wait_o[0] == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      int entry;
      pin = 0; launch = 0; stop = 0; night = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lit("reset_state", state_o[0], 0);
      lit("reset_distance", dist_o[0], 0);
      lit("reset_price", price_o[0], 0);
      lit("reset_overflow", ovf_o[0], 0);

      // Day trip: fare steps only on units 4 and 5.
      tap_launch(1'b0);
      lit("t1_launch_price", price_o[0], 80);
      lit("t1_launch_state", state_o[0], 1);
      pulses(12);
      lit("t1_dist_after12", dist_o[0], 3);
      lit("t1_price_after12", price_o[0], 80);
      pulses(4);
      lit("t1_price_after16", price_o[0], 95);
      pulses(4);
      lit("t1_distance", dist_o[0], 5);
      lit("t1_price", price_o[0], 110);
      tap_stop();
      lit("t1_hold_state", state_o[0], 3);
      tap_stop();
      lit("t1_idle_state", state_o[0], 0);
      lit("t1_idle_price", price_o[0], 0);

      // Night trip with a mid-trip toggle of night_mode.
      tap_launch(1'b1);
      pulses(10);
      night = 1'b0;
      pulses(10);
      lit("t2_price", price_o[0], 120);
      lit("t2_distance", dist_o[0], 5);
      tap_stop();
      tap_stop();

      // Waiting: entry latency from pin rise, then charges every 50 cycles.
      tap_launch(1'b0);
      pulses(4);
      lit("t3_distance", dist_o[0], 1);
      wait_for_wait(n);
      lit("t3_wait_latency_from_pin", cyc - last_rise, 103);
      entry = cyc;
      repeat (55) @(negedge clk);
      lit("t3_price_1charge", price_o[0], 85);
      repeat (105) @(negedge clk);
      lit("t3_price_3charges", price_o[0], 95);
      lit("t3_waiting_high", wait_o[0], 1);
      pulses(1);
      lit("t3_resume_state", state_o[0], 1);
      lit("t3_resume_waiting", wait_o[0], 0);

      // Stop coincident with the edge that would complete unit 2.
      pulses(2);
      @(negedge clk); pin = 1'b1;
      @(negedge clk);
      @(negedge clk); pin = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      lit("t4_fare_valid", fv_o[0], 1);
      lit("t4_state_hold", state_o[0], 3);
      lit("t4_distance_kept", dist_o[0], 1);
      lit("t4_price_kept", price_o[0], 95);
      @(negedge clk);
      lit("t4_fare_valid_drop", fv_o[0], 0);
      pulses(4);
      lit("t4_hold_ignores_edges", dist_o[0], 1);
      tap_stop();
      lit("t4_idle_state", state_o[0], 0);
      lit("t4_idle_distance", dist_o[0], 0);
      lit("t4_idle_price", price_o[0], 0);
      tap_launch(1'b0);
      pulses(4);
      tap_stop();
      @(negedge clk); launch = 1'b1; stop = 1'b1;
      @(negedge clk); launch = 1'b0; stop = 1'b0;
      lit("t4_relaunch_state", state_o[0], 1);
      lit("t4_relaunch_price", price_o[0], 80);
      lit("t4_relaunch_distance", dist_o[0], 0);

      // Saturation on the 8-bit core; the 20-bit core sees the same trip unclamped.
      pulses(40);
      lit("t5_d1_price", price_o[1], 255);
      lit("t5_d1_overflow", ovf_o[1], 1);
      lit("t5_d1_distance", dist_o[1], 10);
      lit("t5_d0_price", price_o[0], 185);
      lit("t5_d0_overflow", ovf_o[0], 0);
      tap_stop();
      tap_launch(1'b0);
      lit("t5_d1_overflow_cleared", ovf_o[1], 0);
      lit("t5_d1_price_relaunch", price_o[1], 80);

      // Asynchronous reset in WAIT.
      pulses(4);
      wait_for_wait(n);
      lit("t6_in_wait", state_o[0], 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      lit("t6_rst_state", state_o[0], 0);
      lit("t6_rst_distance", dist_o[0], 0);
      lit("t6_rst_price", price_o[0], 0);
      lit("t6_rst_waiting", wait_o[0], 0);
      lit("t6_rst_d1_price", price_o[1], 0);
      lit("t6_rst_d1_distance", dist_o[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lit("t6_after_release_state", state_o[0], 0);
      lit("t6_after_release_price", price_o[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/taxi_meter_core.md
# taxi_meter_core

Parametrised fare-metering core for the taxi meter. It sits between the key debouncers and the binary-to-BCD/display chain, replacing the separate distance and price counters with a single synchronous engine. It synchronises the raw encoder pulse train and runs a trip state machine (idle/run/wait/hold). It accumulates distance and a fare built from base fare, day/night per-unit rate and waiting-time charge, with saturation and an end-of-trip strobe.

## Interface
Parameters:
- PULSES_PER_UNIT, 10: encoder rising edges per distance unit (≥2).
- BASE_FARE, 80: price loaded at trip start (price units).
- BASE_DIST, 3: distance units covered by base fare.
- RATE_DAY, 15: price added per unit beyond BASE_DIST, day mode.
- RATE_NIGHT, 20: same, night mode.
- WAIT_TICKS, 100_000_000: cycles without an encoder edge before entering WAIT.
- WAIT_CHARGE_TICKS, 50_000_000: cycles per waiting charge while in WAIT.
- WAIT_RATE, 5: price added per waiting charge.
- DIST_W, 20: distance width.
- PRICE_W, 20: price width.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- encoder_pulses  in  1  raw asynchronous encoder input.
- flag_launch  in  1  one-cycle debounced launch pulse.
- flag_stop  in  1  one-cycle debounced stop pulse.
- night_mode  in  1  level; sampled only on accepted launch.
- distance  out  DIST_W  distance units, registered.
- price  out  PRICE_W  fare, registered.
- state  out  2  0 IDLE, 1 RUN, 2 WAIT, 3 HOLD.
- waiting  out  1  high in WAIT.
- fare_valid  out  1  one-cycle pulse on entry to HOLD.
- overflow  out  1  sticky; set when distance or price saturates.

## Operation
- Encoder input: 2-FF synchroniser, then a rising-edge detector producing an internal one-cycle edge.
- IDLE: distance = 0, price = 0, internal counters cleared.
  - launch → RUN: price ← BASE_FARE, distance ← 0, pulse/idle/wait counters ← 0, overflow ← 0, night latched. Stop ignored.
- RUN: each edge increments the pulse counter.
  - On the edge that makes it PULSES_PER_UNIT, the counter wraps to 0 and distance increments.
  - If the new distance > BASE_DIST, price += latched rate in the same cycle.
  - Idle counter clears on every edge and otherwise increments. When it reaches WAIT_TICKS−1 → WAIT with wait counter ← 0.
- WAIT: wait counter increments each cycle. On reaching WAIT_CHARGE_TICKS−1 it wraps and price += WAIT_RATE.
  - An edge → RUN. That edge is counted as in RUN, idle counter ← 0, and the partial wait count is discarded.
- RUN/WAIT + stop → HOLD and fare_valid pulses.
  - Stop has priority over a same-cycle edge (edge discarded), a wait charge, or launch.
  - Launch in RUN/WAIT is ignored.
- HOLD: outputs frozen and edges ignored.
  - launch → RUN as a fresh trip (same actions as from IDLE).
  - stop → IDLE.
  - Launch and stop in the same cycle: launch wins.
- Saturation: a distance or price addition that would exceed all-ones clamps to all-ones and sets overflow. Further additions hold the value. overflow clears only on accepted launch or reset.
- night_mode changes after launch have no effect until the next launch.

## Timing
- Reset (asynchronous, immediate): state IDLE, distance 0, price 0, waiting 0, fare_valid 0, overflow 0, synchroniser and all counters 0.
  - Reset mid-trip discards the trip entirely.
- Encoder pin rises before clock edge k → internal edge pulse is high in cycle after edge k+1 → distance/price update visible after edge k+2. Pin-to-output latency is 3 clock edges.
- Encoder high and low phases must each be ≥2 clock cycles. Shorter pulses may be missed.
- flag_launch/flag_stop act at the next clock edge. state, price and distance are updated at that same edge, and fare_valid is high for exactly the following cycle.
- WAIT entry: exactly WAIT_TICKS cycles after the last accepted edge. waiting rises with state.
- First waiting charge: WAIT_CHARGE_TICKS cycles after WAIT entry, then every WAIT_CHARGE_TICKS cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
Parameters for tests 1–4: PULSES_PER_UNIT=4, BASE_FARE=80, BASE_DIST=3, RATE_DAY=15, RATE_NIGHT=20, WAIT_TICKS=100, WAIT_CHARGE_TICKS=50, WAIT_RATE=5.

1. Reset, launch with night=0, 20 encoder pulses (4-cycle period) → distance=5, price=110, state=1, and price steps only at units 4 and 5.
2. Launch with night=1, 20 pulses, toggle night mid-trip → price=120 and the toggle has no effect.
3. Launch, 4 pulses, then no pulses for 250 cycles → WAIT entered 100 cycles after the last edge and price=95 after 3 charges. Next pulse → state=1, waiting=0.
4. Stop in RUN coincident with an edge → state=3, fare_valid high 1 cycle, distance unchanged by that edge, later pulses ignored. Stop → IDLE with zeros. Launch from HOLD → price=80, distance=0.
5. PRICE_W=8, RATE_DAY=100, 40 pulses → price=255, overflow=1. Next launch clears overflow.
6. Assert sys_rst_n low asynchronously mid-WAIT → all outputs zero immediately, and state=0 after release.
